// File: rtl/lift_ctrl_if.sv
// Request/status bundle between the request encoder and lift_ctrl.
// LIFT_DIR_OUT_EN adds the registered direction indicators o_up/o_dn.
interface lift_ctrl_if;
    logic [1:0] in_f;
    logic [2:0] o_f;
    logic       o_r;
`ifdef LIFT_DIR_OUT_EN
    logic       o_up;
    logic       o_dn;

    modport master (output in_f, input o_f, o_r, o_up, o_dn);
    modport slave  (input in_f, output o_f, o_r, o_up, o_dn);
`else
    modport master (output in_f, input o_f, o_r);
    modport slave  (input in_f, output o_f, o_r);
`endif
endinterface

// File: rtl/lift_ctrl.sv
// Four-floor elevator controller: moves one floor per STEP_CYCLES toward in_f+1.
// Optional macro LIFT_DIR_OUT_EN exposes registered o_up/o_dn direction flags.
module lift_ctrl #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    lift_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

    state_t     st, st_nxt;
    logic [7:0] cnt, cnt_nxt, cnt_eff;
    logic [2:0] f_q, f_nxt, tgt;
    logic       r_q, r_nxt;

    assign tgt = {1'b0, bus.in_f} + 3'd1;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
        cnt_eff = '0;
        f_nxt   = f_q;

        if (tgt > f_q)      st_nxt = UP;
        else if (tgt < f_q) st_nxt = DOWN;

        // A direction change (or leaving IDLE) restarts the floor timer.
        if (st_nxt == st) cnt_eff = cnt;

        if (st_nxt != IDLE) begin
            if (cnt_eff == STEP_LAST) begin
                f_nxt   = (st_nxt == UP) ? f_q + 3'd1 : f_q - 3'd1;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_eff + 8'd1;
            end
        end

        r_nxt = (f_nxt == tgt);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            st  <= IDLE;
            cnt <= '0;
            f_q <= 3'd1;
            r_q <= 1'b0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            f_q <= f_nxt;
            r_q <= r_nxt;
        end
    end

    assign bus.o_f = f_q;
    assign bus.o_r = r_q;

`ifdef LIFT_DIR_OUT_EN
    logic up_q, dn_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            up_q <= 1'b0;
            dn_q <= 1'b0;
        end else begin
            up_q <= (st_nxt == UP);
            dn_q <= (st_nxt == DOWN);
        end
    end

    assign bus.o_up = up_q;
    assign bus.o_dn = dn_q;
`endif
endmodule

// File: tb/tb_lift_ctrl.sv
// Self-checking bench for lift_ctrl: directed scenarios plus random requests
// checked against a floor/progress reference model, for STEP_CYCLES 1 and 3.
module tb_lift_ctrl;
    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic [1:0] req = 2'd3;

    int errors = 0;
    int checks = 0;

    lift_ctrl_if b1 ();
    lift_ctrl_if b3 ();
    assign b1.in_f = req;
    assign b3.in_f = req;

    lift_ctrl #(.STEP_CYCLES(1)) u1 (.in_clk(in_clk), .in_rst_n(in_rst_n), .bus(b1));
    lift_ctrl #(.STEP_CYCLES(3)) u3 (.in_clk(in_clk), .in_rst_n(in_rst_n), .bus(b3));

    always #5 in_clk = ~in_clk;

    // Reference model: index 0 tracks STEP_CYCLES=1, index 1 tracks STEP_CYCLES=3.
    int m_step  [2] = '{1, 3};
    int m_floor [2];
    int m_prog  [2];
    int m_dir   [2];
    int m_r     [2];

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_floor[k] = 1; m_prog[k] = 0; m_dir[k] = 0; m_r[k] = 0;
        end
    endtask

    task automatic model_edge();
        int tgt, d;
        tgt = int'(req) + 1;
        for (int k = 0; k < 2; k++) begin
            d = (tgt > m_floor[k]) ? 1 : (tgt < m_floor[k]) ? -1 : 0;
            if (d == 0) begin
                m_prog[k] = 0;
            end else begin
                if (d != m_dir[k]) m_prog[k] = 0;
                m_prog[k]++;
                if (m_prog[k] == m_step[k]) begin
                    m_floor[k] += d;
                    m_prog[k] = 0;
                end
            end
            m_dir[k] = d;
            m_r[k] = (m_floor[k] == tgt) ? 1 : 0;
        end
    endtask

    task automatic check_models(input string tag);
        check({tag, "/s1_f"}, b1.o_f, 3'(m_floor[0]));
        check({tag, "/s1_r"}, 3'(b1.o_r), 3'(m_r[0]));
        check({tag, "/s3_f"}, b3.o_f, 3'(m_floor[1]));
        check({tag, "/s3_r"}, 3'(b3.o_r), 3'(m_r[1]));
`ifdef LIFT_DIR_OUT_EN
        check({tag, "/s1_up"}, 3'(b1.o_up), 3'(m_dir[0] == 1));
        check({tag, "/s1_dn"}, 3'(b1.o_dn), 3'(m_dir[0] == -1));
        check({tag, "/s3_up"}, 3'(b3.o_up), 3'(m_dir[1] == 1));
        check({tag, "/s3_dn"}, 3'(b3.o_dn), 3'(m_dir[1] == -1));
`endif
    endtask

    // One clock edge: advance the model, then sample 1 ns after the edge.
    task automatic step(input string tag);
        @(posedge in_clk);
        if (in_rst_n) model_edge();
        else          model_reset();
        #1;
        check_models(tag);
    endtask

    task automatic expect1(input string tag, input int f, input int r);
        check({tag, "_f"}, b1.o_f, 3'(f));
        check({tag, "_r"}, 3'(b1.o_r), 3'(r));
    endtask

    initial begin
        logic [2:0] exp_f3 [7];
        logic       exp_r3 [7];
        logic       exp_up3[7];
        exp_f3  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3};
        exp_r3  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_up3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        model_reset();

        // Reset held with a pending request to floor 4.
        req = 2'd3;
        step("rst0"); step("rst1");
        expect1("rst", 1, 0);
        in_rst_n = 1'b1;
        step("up1"); expect1("up_e1", 2, 0);
        step("up2"); expect1("up_e2", 3, 0);
        step("up3"); expect1("up_e3", 4, 1);
        step("up4"); expect1("up_hold", 4, 1);

        // Floor 4 down to floor 2.
        req = 2'd1;
        step("dn1"); expect1("dn_e1", 3, 0);
        step("dn2"); expect1("dn_e2", 2, 1);

        // One floor up, then down to floor 1.
        req = 2'd2;
        step("one"); expect1("one_up", 3, 1);
        req = 2'd0;
        step("bk1"); expect1("back_e1", 2, 0);
        step("bk2"); expect1("back_e2", 1, 1);

        // Retarget with reversal mid-move.
        req = 2'd3;
        step("rt1"); expect1("rt_e1", 2, 0);
        step("rt2"); expect1("rt_e2", 3, 0);
        req = 2'd0;
        step("rt3"); expect1("rt_rev1", 2, 0);
        step("rt4"); expect1("rt_rev2", 1, 1);

        // Asynchronous reset mid-move, observed before the next edge.
        req = 2'd3;
        step("ar1"); step("ar2"); expect1("ar_pre", 3, 0);
        #2 in_rst_n = 1'b0;
        #1;
        model_reset();
        expect1("async_rst", 1, 0);
        check("async_rst_s3_f", b3.o_f, 3'd1);
        step("ar_hold");
        expect1("async_hold", 1, 0);

        // STEP_CYCLES=3 timing from floor 1 toward floor 3.
        req = 2'd2;
        in_rst_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step("s3");
            check($sformatf("s3_f_e%0d", e + 1), b3.o_f, exp_f3[e]);
            check($sformatf("s3_r_e%0d", e + 1), 3'(b3.o_r), 3'(exp_r3[e]));
`ifdef LIFT_DIR_OUT_EN
            check($sformatf("s3_up_e%0d", e + 1), 3'(b3.o_up), 3'(exp_up3[e]));
`else
            if (exp_up3[e] === 1'bx) check("s3_up_table", 3'd0, 3'd1);
`endif
        end

        // Random requests held for a random number of edges.
        for (int n = 0; n < 80; n++) begin
            req = 2'($urandom_range(0, 3));
            for (int h = $urandom_range(1, 8); h > 0; h--) step($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
